// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: fetches into the instruction register, then steps the
// datapath through DECODE/EXECUTE/MEMORY/WRITEBACK, trapping on illegal opcodes and bus stalls.
module multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        fetch_req,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic [31:0] instruction,
  input  logic        branch_taken,
  output logic        data_req,
  output logic        data_we,
  input  logic        data_ready,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        illegal,
  output logic        bus_error,
  output logic        retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;
  logic        bus_error_q, bus_error_d;

  logic is_opimm, is_op, is_load, is_store, is_branch, is_jal, is_lui;
  logic supported, limit_hit;

  assign is_opimm  = (ir_q[6:0] == OPC_OPIMM);
  assign is_op     = (ir_q[6:0] == OPC_OP);
  assign is_load   = (ir_q[6:0] == OPC_LOAD);
  assign is_store  = (ir_q[6:0] == OPC_STORE);
  assign is_branch = (ir_q[6:0] == OPC_BRANCH);
  assign is_jal    = (ir_q[6:0] == OPC_JAL);
  assign is_lui    = (ir_q[6:0] == OPC_LUI);
  assign supported = is_opimm | is_op | is_load | is_store | is_branch | is_jal | is_lui;
  assign limit_hit = (wait_q == WAIT_LIMIT_C);

  assign instruction = ir_q;
  assign rd          = ir_q[11:7];
  assign illegal     = illegal_q;
  assign bus_error   = bus_error_q;
  assign state       = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ir_q        <= 32'd0;
      wait_q      <= 8'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // The wait counter defaults to zero so that any state change clears it; it only
  // advances while FETCH or MEMORY is stalled on its handshake.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = 8'd0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    fetch_req   = 1'b0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = 2'd0;
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    retired     = 1'b0;

    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ready) begin
          ir_d    = fetch_data;
          state_d = S_DECODE;
        end else if (limit_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        if (!supported) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_src_imm = is_opimm | is_load | is_store | is_lui;
        if (is_load || is_store) begin
          state_d = S_MEMORY;
        end else if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          retired  = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEMORY: begin
        data_req = 1'b1;
        data_we  = is_store;
        if (data_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (limit_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WRITEBACK: begin
        reg_write = (ir_q[11:7] != 5'd0);
        if (is_load) begin
          wb_sel = 2'd1;
        end else if (is_jal) begin
          wb_sel = 2'd2;
        end else if (is_lui) begin
          wb_sel = 2'd3;
        end else begin
          wb_sel = 2'd0;
        end
        pc_write = 1'b1;
        pc_sel   = is_jal;
        retired  = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule
